// File: rtl/seg7_capture_if.sv
// Bundle of the scanned 7-segment bus plus the recovered-digit outputs of seg7_capture.
// The master side drives AN/SEG/clr_err; the slave side is the capture block.
interface seg7_capture_if #(
  parameter int NUM_DIGITS = 8
) ();
  logic [NUM_DIGITS-1:0]   AN;
  logic [6:0]              SEG;
  logic                    clr_err;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   valid;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    upd;
  logic                    err_seg;
  logic                    err_an;

  modport master (
    output AN, SEG, clr_err,
    input  digits, valid, blank, upd, err_seg, err_an
  );

  modport slave (
    input  AN, SEG, clr_err,
    output digits, valid, blank, upd, err_seg, err_an
  );
endinterface

// File: rtl/seg7_capture.sv
// Receive side of a multiplexed 7-segment display: samples AN/SEG, waits for a stable
// one-hot-low dwell, decodes the active-low pattern and stores the nibble per anode position.
module seg7_capture #(
  parameter int NUM_DIGITS = 8,
  parameter int STABLE_CNT = 4
) (
  input  logic          clk,
  input  logic          BTN0,
  seg7_capture_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_TRACK = 2'd1;
  localparam logic [1:0] S_HELD  = 2'd2;
  localparam logic [7:0] STABLE_C = 8'(STABLE_CNT);

  logic [NUM_DIGITS-1:0]   r_an_q;
  logic [6:0]              r_seg_q;
  logic [7:0]              r_cnt;
  logic [1:0]              r_state;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_valid;
  logic [NUM_DIGITS-1:0]   r_blank;
  logic                    r_upd;
  logic                    r_err_seg;
  logic                    r_err_an;

  logic                    w_match;
  logic                    w_onehot_q;
  logic                    w_onehot_in;
  logic                    w_multi;
  logic                    w_run;
  logic [7:0]              w_cnt_next;
  logic                    w_commit;
  logic [5:0]              w_dec;
  logic                    w_seg_err;
  logic [1:0]              w_state_next;

  // {legal, blank, nibble}; illegal patterns return all zeros
  function automatic logic [5:0] decode(input logic [6:0] seg);
    case (seg)
      7'b1000000: decode = 6'b10_0000;
      7'b1111001: decode = 6'b10_0001;
      7'b0100100: decode = 6'b10_0010;
      7'b0110000: decode = 6'b10_0011;
      7'b0011001: decode = 6'b10_0100;
      7'b0010010: decode = 6'b10_0101;
      7'b0000010: decode = 6'b10_0110;
      7'b1111000: decode = 6'b10_0111;
      7'b0000000: decode = 6'b10_1000;
      7'b0010000: decode = 6'b10_1001;
      7'b0001000: decode = 6'b10_1010;
      7'b0000011: decode = 6'b10_1011;
      7'b1000110: decode = 6'b10_1100;
      7'b0100001: decode = 6'b10_1101;
      7'b0000110: decode = 6'b10_1110;
      7'b0001110: decode = 6'b10_1111;
      7'b1111111: decode = 6'b01_0000;
      default:    decode = 6'b00_0000;
    endcase
  endfunction

  function automatic logic [3:0] low_count(input logic [NUM_DIGITS-1:0] an);
    low_count = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an[i]) low_count = low_count + 4'd1;
    end
  endfunction

  assign w_match     = (bus.AN == r_an_q) && (bus.SEG == r_seg_q);
  assign w_onehot_q  = (low_count(r_an_q) == 4'd1);
  assign w_onehot_in = (low_count(bus.AN) == 4'd1);
  assign w_multi     = (low_count(bus.AN) > 4'd1);
  assign w_run       = w_match && w_onehot_q;
  assign w_cnt_next  = (r_cnt == STABLE_C) ? r_cnt : r_cnt + 8'd1;
  assign w_commit    = w_run && (r_state != S_HELD) && (w_cnt_next == STABLE_C);
  assign w_dec       = decode(r_seg_q);
  assign w_seg_err   = w_commit && !w_dec[5] && !w_dec[4];

  always_comb begin
    w_state_next = S_IDLE;
    if (w_run) begin
      w_state_next = (w_commit || (r_state == S_HELD)) ? S_HELD : S_TRACK;
    end else if (w_onehot_in) begin
      w_state_next = S_TRACK;
    end
  end

  always_ff @(posedge clk or negedge BTN0) begin
    if (!BTN0) begin
      r_an_q    <= '1;
      r_seg_q   <= 7'h7F;
      r_cnt     <= 8'd0;
      r_state   <= S_IDLE;
      r_digits  <= '0;
      r_valid   <= '0;
      r_blank   <= '0;
      r_upd     <= 1'b0;
      r_err_seg <= 1'b0;
      r_err_an  <= 1'b0;
    end else begin
      r_an_q    <= bus.AN;
      r_seg_q   <= bus.SEG;
      r_cnt     <= w_run ? w_cnt_next : 8'd0;
      r_state   <= w_state_next;
      r_upd     <= w_commit;
      r_err_seg <= (r_err_seg && !bus.clr_err) || w_seg_err;
      r_err_an  <= (r_err_an && !bus.clr_err) || w_multi;
      if (w_commit) begin
        // Only the position whose anode is low in the held sample is touched
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (!r_an_q[k]) begin
            if (w_dec[5]) begin
              r_digits[4*k +: 4] <= w_dec[3:0];
              r_valid[k]         <= 1'b1;
              r_blank[k]         <= 1'b0;
            end else if (w_dec[4]) begin
              r_digits[4*k +: 4] <= 4'd0;
              r_valid[k]         <= 1'b1;
              r_blank[k]         <= 1'b1;
            end else begin
              r_valid[k]         <= 1'b0;
              r_blank[k]         <= 1'b0;
            end
          end
        end
      end
    end
  end

  assign bus.digits  = r_digits;
  assign bus.valid   = r_valid;
  assign bus.blank   = r_blank;
  assign bus.upd     = r_upd;
  assign bus.err_seg = r_err_seg;
  assign bus.err_an  = r_err_an;

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: directed scenarios plus randomized dwells, every cycle compared
// against a run-length reference model of the capture rules.
module tb_seg7_capture;
  localparam int ND = 8;
  localparam int SC = 4;

  logic clk = 1'b0;
  logic btn = 1'b0;
  always #5 clk = ~clk;

  seg7_capture_if #(.NUM_DIGITS(ND)) bus();

  seg7_capture #(.NUM_DIGITS(ND), .STABLE_CNT(SC)) dut (
    .clk  (clk),
    .BTN0 (btn),
    .bus  (bus.slave)
  );

  int n_chk = 0;
  int n_bad = 0;
  int upd_seen;

  logic [6:0] pat [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Reference state: per-position arrays and a count of identical one-hot samples
  logic [3:0]    m_dig [ND];
  bit            m_val [ND];
  bit            m_blk [ND];
  bit            m_upd, m_eseg, m_ean;
  int            run;
  logic [ND-1:0] p_an;
  logic [6:0]    p_seg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ND; i++) begin
      m_dig[i] = 4'd0; m_val[i] = 1'b0; m_blk[i] = 1'b0;
    end
    m_upd = 0; m_eseg = 0; m_ean = 0; run = 0;
    p_an = '1; p_seg = 7'h7F;
  endtask

  task automatic model_step();
    int lows, k, v;
    bit new_seg;
    lows = 0; k = 0; v = -1; new_seg = 0;
    if (!btn) begin
      model_reset();
      return;
    end
    for (int i = 0; i < ND; i++) if (!bus.AN[i]) begin lows++; k = i; end
    if (lows == 1 && bus.AN == p_an && bus.SEG == p_seg) run++;
    else run = (lows == 1) ? 1 : 0;
    if (run > 1000) run = 1000;
    m_upd = (run == SC + 1);
    if (m_upd) begin
      for (int j = 0; j < 16; j++) if (pat[j] == bus.SEG) v = j;
      if (v >= 0) begin
        m_dig[k] = 4'(v); m_val[k] = 1; m_blk[k] = 0;
      end else if (bus.SEG == 7'h7F) begin
        m_dig[k] = 4'd0; m_val[k] = 1; m_blk[k] = 1;
      end else begin
        m_val[k] = 0; m_blk[k] = 0; new_seg = 1;
      end
    end
    m_eseg = (m_eseg && !bus.clr_err) || new_seg;
    m_ean  = (m_ean && !bus.clr_err) || (lows > 1);
    p_an = bus.AN; p_seg = bus.SEG;
  endtask

  task automatic check_all();
    logic [4*ND-1:0] d;
    logic [ND-1:0]   va, bl;
    for (int i = 0; i < ND; i++) begin
      d[4*i +: 4] = m_dig[i]; va[i] = m_val[i]; bl[i] = m_blk[i];
    end
    chk("digits", bus.digits, d);
    chk("valid", bus.valid, va);
    chk("blank", bus.blank, bl);
    chk("upd", bus.upd, m_upd);
    chk("err_seg", bus.err_seg, m_eseg);
    chk("err_an", bus.err_an, m_ean);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    if (bus.upd) upd_seen++;
  endtask

  task automatic hold(input logic [ND-1:0] an, input logic [6:0] seg, input int n);
    bus.AN = an; bus.SEG = seg;
    repeat (n) cycle();
  endtask

  task automatic frame(input int blank_pos);
    logic [ND-1:0] a;
    for (int k = 0; k < ND; k++) begin
      a = '1; a[k] = 1'b0;
      hold(a, (k == blank_pos) ? 7'h7F : pat[k], 10);
    end
  endtask

  initial begin
    int first_upd;
    logic [ND-1:0] a;
    model_reset();
    upd_seen = 0;
    bus.AN = '1; bus.SEG = 7'h7F; bus.clr_err = 1'b0;

    // T1: reset held while the bus toggles
    for (int i = 0; i < 6; i++) begin
      bus.AN = ND'($urandom); bus.SEG = 7'($urandom);
      cycle();
    end
    chk("t1_valid_in_reset", bus.valid, 0);
    btn = 1'b1;
    hold('1, 7'h7F, 3);
    chk("t1_digits_after_release", bus.digits, 0);

    // T2: single stable digit
    upd_seen = 0;
    hold(8'hFE, 7'b0100100, 10);
    chk("t2_upd_pulses", upd_seen, 1);
    chk("t2_digit0", bus.digits[3:0], 4'd2);
    chk("t2_valid0", bus.valid[0], 1'b1);

    // T3: dwell too short to commit
    upd_seen = 0;
    hold(8'hFB, 7'b1111000, 3);
    hold(8'hFF, 7'b1111000, 4);
    chk("t3_no_upd", upd_seen, 0);
    chk("t3_valid2", bus.valid[2], 1'b0);

    // T4: error flags
    hold(8'hFC, 7'b1000000, 3);
    chk("t4_err_an", bus.err_an, 1'b1);
    hold(8'hF7, 7'b0101010, 8);
    chk("t4_err_seg", bus.err_seg, 1'b1);
    chk("t4_valid3", bus.valid[3], 1'b0);
    bus.clr_err = 1'b1;
    hold(8'hFF, 7'h7F, 1);
    bus.clr_err = 1'b0;
    hold(8'hFF, 7'h7F, 1);
    chk("t4_clr_err_an", bus.err_an, 1'b0);
    chk("t4_clr_err_seg", bus.err_seg, 1'b0);
    bus.clr_err = 1'b1;
    hold(8'hFC, 7'h7F, 1);
    bus.clr_err = 1'b0;
    hold(8'hFF, 7'h7F, 1);
    chk("t4_err_wins_clr", bus.err_an, 1'b1);

    // T5: full scan frames, then one with digit 5 blank
    for (int f = 0; f < 2; f++) begin
      upd_seen = 0;
      frame(-1);
      chk("t5_upd_per_frame", upd_seen, 8);
    end
    chk("t5_digits", bus.digits, 32'h76543210);
    chk("t5_valid", bus.valid, 8'hFF);
    frame(5);
    chk("t5_blank5", bus.blank[5], 1'b1);
    chk("t5_digit5_zero", bus.digits[23:20], 4'd0);
    chk("t5_digits_blank", bus.digits, 32'h76043210);

    // T6: reset in the middle of a dwell
    hold(8'hFE, 7'b1111001, 3);
    btn = 1'b0;
    hold(8'hFE, 7'b1111001, 1);
    chk("t6_valid_reset", bus.valid, 0);
    chk("t6_digits_reset", bus.digits, 0);
    btn = 1'b1;
    first_upd = 0;
    for (int c = 1; c <= 12; c++) begin
      hold(8'hFE, 7'b1111001, 1);
      if (bus.upd && first_upd == 0) first_upd = c;
    end
    chk("t6_commit_latency", first_upd, SC + 1);
    chk("t6_digit0", bus.digits[3:0], 4'd1);

    // Randomized dwells
    for (int n = 0; n < 200; n++) begin
      int r, len;
      logic [6:0] s;
      r = $urandom_range(0, 99);
      if (r < 70) s = pat[$urandom_range(0, 15)];
      else if (r < 80) s = 7'h7F;
      else s = 7'($urandom);
      a = '1;
      a[$urandom_range(0, ND - 1)] = 1'b0;
      r = $urandom_range(0, 99);
      if (r < 8) a = ND'($urandom);
      else if (r < 12) a = '1;
      len = $urandom_range(1, 9);
      bus.AN = a; bus.SEG = s;
      for (int c = 0; c < len; c++) begin
        bus.clr_err = ($urandom_range(0, 99) < 6);
        btn = !($urandom_range(0, 999) < 8);
        cycle();
        btn = 1'b1;
      end
      bus.clr_err = 1'b0;
    end
    hold('1, 7'h7F, 2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
